alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter and sequencer for the shared combinational 32-bit ALU. It accepts operation requests from two requesters over valid/ready handshakes and evaluates each request's 4-bit ARM condition code against an architectural NZCV flag register. It drives the ALU for one cycle, returns the result on a per-requester response handshake, and updates NZCV from the ALU status outputs. It sits between the decode/issue stages and the single ALU instance.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted this cycle (bit i)
- req_op  in  8  {op1,op0}, 4-bit ALU opcode per requester
- req_cond  in  8  {cond1,cond0}, ARM condition field
- req_s  in  2  set-flags bit per requester
- req_a  in  2*WIDTH  {a1,a0} operand 1
- req_b  in  2*WIDTH  {b1,b0} operand 2
- resp_valid  out  2  response valid (bit i)
- resp_ready  in  2  response consumed (bit i)
- resp_result  out  WIDTH  ALU result of the operation being returned
- resp_exec  out  1  1 = condition passed and op executed
- resp_wb  out  1  1 = result is to be written back
- alu_op  out  4  to ALU opcode
- alu_a, alu_b  out  WIDTH each  to ALU operands
- alu_result  in  WIDTH  from ALU
- alu_n, alu_z, alu_c, alu_v  in  1 each  ALU status flags
- flags_nzcv  out  4  architectural flags {N,Z,C,V}

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitrate among asserted req_valid bits.
  - If exactly one requester is valid, grant it. If both are valid, grant the one not granted last; the pointer resets so requester 0 wins the first tie.
  - req_ready[g] is high combinationally for the granted g only.
  - On the handshake, latch op/cond/s/a/b and g, then go to EXEC.
  - Requesters must hold valid and payload until ready.
- EXEC:
  - alu_op/alu_a/alu_b are driven from the latches (registered outputs, held until the next accept).
  - Evaluate the condition against flags_nzcv: EQ 0000 Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1110 always passes; 1111 never passes.
  - Capture alu_result into resp_result and record the exec bit.
  - Set wb = exec and the opcode is not CMP (1010), TST (1000) or TEQ (1001).
  - Flag update, only when exec=1 and (s=1 or the op is CMP/TST/TEQ):
    - N and Z are always loaded from the ALU.
    - C and V are loaded only for ADD (0100) and SUB (0010) and retained for every other op.
  - Go to RESP.
- RESP:
  - resp_valid[g] is high and resp_result/resp_exec/resp_wb are stable.
  - On resp_ready[g], clear resp_valid, flip the round-robin pointer to favour the other requester, and return to IDLE.
  - resp_ready of the non-granted bit is ignored.
- Failed condition: resp_exec=0, resp_wb=0, flags unchanged; resp_result still carries the ALU output.
- Unknown opcodes pass through to the ALU (result 0); the same flag rules apply.

## Timing
- Reset (rst_n low at an edge) forces:
  - state IDLE, flags_nzcv=0000, pointer favours requester 0
  - req_ready=00 (forced low while rst_n low), resp_valid=00
  - resp_result=0, resp_exec=0, resp_wb=0, alu_op=0, alu_a=alu_b=0
- Reset mid-operation drops the in-flight op: no response is issued and no flag update occurs.
- Latency:
  - Accept at edge T; EXEC during cycle T+1; resp_valid is high from T+2.
  - flags_nzcv shows the new value from T+2.
- Throughput: at most one op per 3 cycles when resp_ready is tied high.
- A request asserted during EXEC or RESP waits, with req_ready low.
- The condition of op k+1 is evaluated against flags already updated by op k; strict serialization, no forwarding hazard.
- A requester's valid dropping before ready is illegal and not handled.

## Test plan
- Reset, then req0: ADD 0x7FFFFFFF+1, cond=1110, s=1 -> accepted at T, resp_valid[0] at T+2, result 0x80000000, exec=1, wb=1, NZCV=1001.
- Both requesters valid continuously with op MOV and cond AL -> grants alternate 0,1,0,1; each response 3 cycles apart with resp_ready high.
- CMP 5,5 (s=0) -> NZCV=01xx with C/V retained from the prior value; wb=0. Then cond EQ ADD 1+1 -> exec=1, result 2. Then cond NE -> exec=0, wb=0, flags unchanged.
- SUB 0x80000000-1, s=1 -> V=1, N=0. Then GE -> fails, LT -> passes. Then cond 1111 -> exec=0.
- resp_ready held low for 5 cycles -> resp_valid and result stable; req1 valid meanwhile sees req_ready low; after release, req1 is granted next.
- rst_n pulsed low during EXEC -> no resp_valid, flags_nzcv=0000, next op is accepted normally.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Request/response bundle between the two issue-side requesters and the
//   ALU arbiter. Bit i of every 2-bit vector and slice i of every packed
//   payload belongs to requester i.
//   req_valid/req_ready   : request handshake, one bit per requester
//   req_op/req_cond/req_s : {op1,op0}, {cond1,cond0}, set-flags bits
//   req_a/req_b           : {a1,a0}, {b1,b0} operands
//   resp_valid/resp_ready : response handshake, one bit per requester
//   resp_result/exec/wb   : shared response payload for the granted requester
//   Modports: slave = arbiter side, master = requester side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [7:0]         req_op;
  logic [7:0]         req_cond;
  logic [1:0]         req_s;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [1:0]         resp_valid;
  logic [1:0]         resp_ready;
  logic [WIDTH-1:0]   resp_result;
  logic               resp_exec;
  logic               resp_wb;

  modport slave (
    input  req_valid, req_op, req_cond, req_s, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_exec, resp_wb
  );

  modport master (
    output req_valid, req_op, req_cond, req_s, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_exec, resp_wb
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-port round-robin arbiter/sequencer in front of one shared
//   combinational ALU. Each operation goes IDLE (accept) -> EXEC (ALU is
//   driven, condition checked, result and flags captured) -> RESP (result
//   held until the granted requester takes it). NZCV is the architectural
//   flag register; conditions of an op see all flag updates of earlier ops.
//   Ports:
//     clk, rst_n       : clock, synchronous active-low reset
//     bus              : request/response bundle (alu_arbiter_if.slave)
//     alu_op/a/b       : registered drive to the ALU
//     alu_result/n/z/c/v : ALU result and status
//     flags_nzcv       : architectural flags {N,Z,C,V}
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic [3:0]       flags_nzcv
);

  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // ARM condition-code check against the current NZCV value.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, pass;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  // Compare-class ops only produce flags, never a write-back.
  function automatic logic is_test_op(input logic [3:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP);
  endfunction

  // N/Z always come from the ALU; C/V only from the arithmetic ops.
  function automatic logic [3:0] flags_next(input logic [3:0] op, input logic [3:0] cur,
                                            input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] nxt;
    if ((op == OP_ADD) || (op == OP_SUB)) begin
      nxt = {n, z, c, v};
    end else begin
      nxt = {n, z, cur[1:0]};
    end
    return nxt;
  endfunction

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;       // favoured requester on a tie
  logic             gnt_q, gnt_d;       // requester owning the in-flight op
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       cond_q, cond_d;
  logic             s_q, s_d;
  logic [3:0]       flags_q, flags_d;
  logic [1:0]       resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exec_q, exec_d;
  logic             wb_q, wb_d;
  logic [1:0]       req_ready_s;
  logic             pick_s;
  logic             pass_s;

  // Arbitration, next-state and datapath next values.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cond_d       = cond_q;
    s_d          = s_q;
    flags_d      = flags_q;
    resp_valid_d = resp_valid_q;
    result_d     = result_q;
    exec_d       = exec_q;
    wb_d         = wb_q;
    req_ready_s  = 2'b00;
    pick_s       = 1'b0;
    pass_s       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid == 2'b11) begin
          pick_s = ptr_q;
        end else if (bus.req_valid[1]) begin
          pick_s = 1'b1;
        end else begin
          pick_s = 1'b0;
        end

        if (bus.req_valid != 2'b00) begin
          // Ready goes to the winner alone; it is already holding payload,
          // so the handshake completes at this edge.
          req_ready_s = pick_s ? 2'b10 : 2'b01;
          gnt_d       = pick_s;
          op_d        = pick_s ? bus.req_op[7:4]   : bus.req_op[3:0];
          cond_d      = pick_s ? bus.req_cond[7:4] : bus.req_cond[3:0];
          s_d         = pick_s ? bus.req_s[1]      : bus.req_s[0];
          a_d         = pick_s ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
          b_d         = pick_s ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
          state_d     = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_EXEC: begin
        pass_s   = cond_pass(cond_q, flags_q);
        result_d = alu_result;
        exec_d   = pass_s;
        wb_d     = pass_s & ~is_test_op(op_q);
        if (pass_s && (s_q || is_test_op(op_q))) begin
          flags_d = flags_next(op_q, flags_q, alu_n, alu_z, alu_c, alu_v);
        end else begin
          flags_d = flags_q;
        end
        resp_valid_d = gnt_q ? 2'b10 : 2'b01;
        state_d      = ST_RESP;
      end

      ST_RESP: begin
        // Only the owner's resp_ready can close the transaction.
        if (bus.resp_ready[gnt_q]) begin
          resp_valid_d = 2'b00;
          ptr_d        = ~gnt_q;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 2'b00;
      end
    endcase
  end

  // State and datapath registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      gnt_q        <= 1'b0;
      op_q         <= 4'd0;
      a_q          <= {WIDTH{1'b0}};
      b_q          <= {WIDTH{1'b0}};
      cond_q       <= 4'd0;
      s_q          <= 1'b0;
      flags_q      <= 4'd0;
      resp_valid_q <= 2'b00;
      result_q     <= {WIDTH{1'b0}};
      exec_q       <= 1'b0;
      wb_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cond_q       <= cond_d;
      s_q          <= s_d;
      flags_q      <= flags_d;
      resp_valid_q <= resp_valid_d;
      result_q     <= result_d;
      exec_q       <= exec_d;
      wb_q         <= wb_d;
    end
  end

  // Ready is combinational, so it is gated off while reset is asserted.
  assign bus.req_ready   = rst_n ? req_ready_s : 2'b00;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = result_q;
  assign bus.resp_exec   = exec_q;
  assign bus.resp_wb     = wb_q;
  assign alu_op          = op_q;
  assign alu_a           = a_q;
  assign alu_b           = b_q;
  assign flags_nzcv      = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic [3:0]  flags_nzcv;

  int total = 0;
  int bad   = 0;
  logic [3:0] flags_m;   // reference NZCV
  logic       fav_m;     // reference tie winner

  alu_arbiter_if #(.WIDTH(32)) bus ();

  alu_arbiter #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_c      (alu_c),
    .alu_v      (alu_v),
    .flags_nzcv (flags_nzcv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {N,Z,C,V,result}
  function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum, diff;
    logic [31:0] r;
    logic c, v;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0, 4'd8:  r = a & b;
      4'd1, 4'd9:  r = a ^ b;
      4'd2, 4'd10: begin r = diff[31:0]; c = ~diff[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd4:        begin r = sum[31:0];  c = sum[32];   v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd12:       r = a | b;
      4'd13:       r = b;
      4'd14:       r = a & ~b;
      4'd15:       r = ~b;
      default:     r = 32'd0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  assign {alu_n, alu_z, alu_c, alu_v, alu_result} = ref_alu(alu_op, alu_a, alu_b);

  // Condition check: even codes test a base predicate, odd codes its inverse.
  function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return cond[0] ? !base : base;
  endfunction

  task automatic model_op(input logic [3:0] op, input logic [3:0] cond, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic ex, output logic wb);
    logic [35:0] pk;
    logic tst;
    pk  = ref_alu(op, a, b);
    tst = (op == 4'd8) || (op == 4'd9) || (op == 4'd10);
    ex  = ref_pass(cond, flags_m);
    wb  = ex && !tst;
    res = pk[31:0];
    if (ex && (s || tst)) begin
      if (op == 4'd4 || op == 4'd2) flags_m = pk[35:32];
      else flags_m = {pk[35:34], flags_m[1:0]};
    end
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [3:0] cond, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_op[r*4 +: 4]    = op;
    bus.req_cond[r*4 +: 4]  = cond;
    bus.req_s[r]            = s;
    bus.req_a[r*32 +: 32]   = a;
    bus.req_b[r*32 +: 32]   = b;
  endtask

  // Drive one request from a negedge and collect the response (no checks).
  task automatic issue(input int r, input logic [3:0] op, input logic [3:0] cond, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       output int acc_wait, output int resp_lat, output logic [31:0] res,
                       output logic ex, output logic wb, output logic [3:0] fl);
    set_req(r, op, cond, s, a, b);
    bus.req_valid[r] = 1'b1;
    acc_wait = 0;
    #1;
    while (bus.req_ready[r] !== 1'b1 && acc_wait < 20) begin
      @(negedge clk); #1; acc_wait++;
    end
    @(negedge clk);
    bus.req_valid[r] = 1'b0;
    resp_lat = 1;
    while (bus.resp_valid[r] !== 1'b1 && resp_lat < 20) begin
      @(negedge clk); resp_lat++;
    end
    res = bus.resp_result;
    ex  = bus.resp_exec;
    wb  = bus.resp_wb;
    fl  = flags_nzcv;
    bus.resp_ready[r] = 1'b1;
    @(negedge clk);
    bus.resp_ready[r] = 1'b0;
    fav_m = (r == 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b00; bus.resp_ready = 2'b00;
    bus.req_op = 8'd0; bus.req_cond = 8'd0; bus.req_s = 2'b00;
    bus.req_a = 64'd0; bus.req_b = 64'd0;
    repeat (3) @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", bus.req_ready); end
    total++; if (flags_nzcv !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags_nzcv); end
    total++; if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp_valid got=%b exp=00", bus.resp_valid); end
    total++; if ({bus.resp_result, bus.resp_exec, bus.resp_wb} !== 34'd0) begin bad++; $display("FAIL reset_resp got=%h/%b/%b exp=0", bus.resp_result, bus.resp_exec, bus.resp_wb); end
    total++; if ({alu_op, alu_a, alu_b} !== 68'd0) begin bad++; $display("FAIL reset_alu got=%h/%h/%h exp=0", alu_op, alu_a, alu_b); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    flags_m = 4'b0000;
    fav_m = 1'b0;
  endtask

  typedef struct {
    int r; logic [3:0] op; logic [3:0] cond; logic s;
    logic [31:0] a; logic [31:0] b; logic [31:0] res; logic ex; logic wb; logic [3:0] fl;
  } dir_t;

  task automatic test_directed();
    dir_t tbl[8];
    int acc, lat;
    logic [31:0] res, mres;
    logic ex, wb, mex, mwb;
    logic [3:0] fl;
    tbl[0] = '{0, 4'd4,  4'b1110, 1'b1, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1, 1'b1, 4'b1001};
    tbl[1] = '{1, 4'd10, 4'b1110, 1'b0, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 4'b0101};
    tbl[2] = '{0, 4'd4,  4'b0000, 1'b0, 32'd1, 32'd1, 32'd2, 1'b1, 1'b1, 4'b0101};
    tbl[3] = '{1, 4'd4,  4'b0001, 1'b1, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 4'b0101};
    tbl[4] = '{0, 4'd2,  4'b1110, 1'b1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b1, 4'b0011};
    tbl[5] = '{1, 4'd13, 4'b1010, 1'b0, 32'd0, 32'h55, 32'h55, 1'b0, 1'b0, 4'b0011};
    tbl[6] = '{0, 4'd13, 4'b1011, 1'b0, 32'd0, 32'h55, 32'h55, 1'b1, 1'b1, 4'b0011};
    tbl[7] = '{1, 4'd4,  4'b1111, 1'b1, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 4'b0011};
    for (int i = 0; i < 8; i++) begin
      model_op(tbl[i].op, tbl[i].cond, tbl[i].s, tbl[i].a, tbl[i].b, mres, mex, mwb);
      issue(tbl[i].r, tbl[i].op, tbl[i].cond, tbl[i].s, tbl[i].a, tbl[i].b, acc, lat, res, ex, wb, fl);
      total++; if (acc !== 0) begin bad++; $display("FAIL dir%0d_accept wait=%0d exp=0", i, acc); end
      total++; if (lat !== 2) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=2", i, lat); end
      total++; if (res !== tbl[i].res) begin bad++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, tbl[i].res); end
      total++; if (ex !== tbl[i].ex) begin bad++; $display("FAIL dir%0d_exec got=%b exp=%b", i, ex, tbl[i].ex); end
      total++; if (wb !== tbl[i].wb) begin bad++; $display("FAIL dir%0d_wb got=%b exp=%b", i, wb, tbl[i].wb); end
      total++; if (fl !== tbl[i].fl) begin bad++; $display("FAIL dir%0d_flags got=%b exp=%b", i, fl, tbl[i].fl); end
    end
  endtask

  task automatic test_random();
    int r, acc, lat;
    logic [3:0] op, cond, fl;
    logic s, ex, wb, mex, mwb;
    logic [31:0] a, b, res, mres;
    for (int i = 0; i < 40; i++) begin
      r    = int'($urandom_range(0, 1));
      op   = 4'($urandom_range(0, 15));
      cond = 4'($urandom_range(0, 15));
      s    = 1'($urandom_range(0, 1));
      a    = $urandom;
      b    = $urandom;
      case ($urandom_range(0, 3))
        0: a = 32'h7FFFFFFF;
        1: b = a;
        2: a = 32'h80000000;
        default: b = b;
      endcase
      model_op(op, cond, s, a, b, mres, mex, mwb);
      issue(r, op, cond, s, a, b, acc, lat, res, ex, wb, fl);
      total++; if (acc !== 0 || lat !== 2) begin bad++; $display("FAIL rnd%0d_timing acc=%0d lat=%0d exp=0/2", i, acc, lat); end
      total++; if (res !== mres) begin bad++; $display("FAIL rnd%0d_result op=%h got=%h exp=%h", i, op, res, mres); end
      total++; if ({ex, wb} !== {mex, mwb}) begin bad++; $display("FAIL rnd%0d_exec_wb cond=%h got=%b%b exp=%b%b", i, cond, ex, wb, mex, mwb); end
      total++; if (fl !== flags_m) begin bad++; $display("FAIL rnd%0d_flags op=%h got=%b exp=%b", i, op, fl, flags_m); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] mres;
    logic mex, mwb;
    int lat;
    model_op(4'd4, 4'b1110, 1'b0, 32'd10, 32'd20, mres, mex, mwb);
    set_req(0, 4'd4, 4'b1110, 1'b0, 32'd10, 32'd20);
    bus.req_valid[0] = 1'b1;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL bp_accept0 got=%b exp=01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    set_req(1, 4'd13, 4'b1110, 1'b0, 32'd0, 32'h77);
    bus.req_valid[1] = 1'b1;
    #1;
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL bp_exec_ready got=%b exp=00", bus.req_ready); end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (bus.resp_valid !== 2'b01 || bus.resp_result !== mres || bus.req_ready !== 2'b00) begin
        bad++; $display("FAIL bp_hold%0d valid=%b result=%h ready=%b exp=01/%h/00", k, bus.resp_valid, bus.resp_result, bus.req_ready, mres);
      end
      @(negedge clk);
    end
    bus.resp_ready = 2'b10;  // wrong requester: ignored
    @(negedge clk);
    total++; if (bus.resp_valid !== 2'b01) begin bad++; $display("FAIL bp_ignore_other got=%b exp=01", bus.resp_valid); end
    bus.resp_ready = 2'b01;
    @(negedge clk);
    bus.resp_ready = 2'b00;
    #1;
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL bp_next_grant got=%b exp=10", bus.req_ready); end
    model_op(4'd13, 4'b1110, 1'b0, 32'd0, 32'h77, mres, mex, mwb);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    lat = 1;
    while (bus.resp_valid[1] !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    total++; if (lat !== 2 || bus.resp_result !== mres) begin bad++; $display("FAIL bp_req1_resp lat=%0d result=%h exp=2/%h", lat, bus.resp_result, mres); end
    bus.resp_ready[1] = 1'b1;
    @(negedge clk);
    bus.resp_ready[1] = 1'b0;
    fav_m = 1'b0;
  endtask

  task automatic test_reset_mid();
    int acc, lat;
    logic [31:0] res, mres;
    logic ex, wb, mex, mwb;
    logic [3:0] fl;
    set_req(0, 4'd4, 4'b1110, 1'b1, 32'h7FFFFFFF, 32'h1);
    bus.req_valid[0] = 1'b1;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rm_accept got=%b exp=01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    flags_m = 4'b0000;
    fav_m = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bus.resp_valid !== 2'b00 || flags_nzcv !== 4'b0000) begin
        bad++; $display("FAIL rm_dropped%0d valid=%b flags=%b exp=00/0000", k, bus.resp_valid, flags_nzcv);
      end
      @(negedge clk);
    end
    model_op(4'd4, 4'b1110, 1'b1, 32'd2, 32'd3, mres, mex, mwb);
    issue(1, 4'd4, 4'b1110, 1'b1, 32'd2, 32'd3, acc, lat, res, ex, wb, fl);
    total++;
    if (acc !== 0 || lat !== 2 || res !== mres || fl !== flags_m || ex !== 1'b1) begin
      bad++; $display("FAIL rm_next_op acc=%0d lat=%0d res=%h fl=%b ex=%b exp=0/2/%h/%b/1", acc, lat, res, fl, ex, mres, flags_m);
    end
  endtask

  task automatic test_back_to_back();
    int g_cnt;
    int g_who[8];
    int g_cyc[8];
    logic [3:0] fl_before;
    logic first;
    fl_before = flags_nzcv;
    first = fav_m;
    g_cnt = 0;
    set_req(0, 4'd13, 4'b1110, 1'b0, 32'd0, 32'h1111);
    set_req(1, 4'd13, 4'b1110, 1'b0, 32'd0, 32'h2222);
    bus.resp_ready = 2'b11;
    bus.req_valid = 2'b11;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (bus.req_ready !== 2'b00 && g_cnt < 8) begin
        g_who[g_cnt] = int'(bus.req_ready[1]);
        g_cyc[g_cnt] = c;
        g_cnt++;
      end
      if (bus.resp_valid !== 2'b00) begin
        total++;
        if (bus.resp_result !== (bus.resp_valid[1] ? 32'h2222 : 32'h1111)) begin
          bad++; $display("FAIL b2b_result c=%0d valid=%b got=%h", c, bus.resp_valid, bus.resp_result);
        end
      end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    repeat (4) @(negedge clk);
    bus.resp_ready = 2'b00;
    total++; if (g_cnt < 5) begin bad++; $display("FAIL b2b_grant_count got=%0d exp>=5", g_cnt); end
    for (int i = 0; i < g_cnt; i++) begin
      total++;
      if (g_who[i] !== (int'(first) ^ (i & 1))) begin bad++; $display("FAIL b2b_order%0d got=%0d exp=%0d", i, g_who[i], int'(first) ^ (i & 1)); end
      if (i > 0) begin
        total++;
        if (g_cyc[i] - g_cyc[i-1] !== 3) begin bad++; $display("FAIL b2b_spacing%0d got=%0d exp=3", i, g_cyc[i] - g_cyc[i-1]); end
      end
    end
    total++; if (flags_nzcv !== fl_before) begin bad++; $display("FAIL b2b_flags got=%b exp=%b", flags_nzcv, fl_before); end
    if (g_cnt > 0) fav_m = (g_who[g_cnt-1] == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
